instr_encoder_loader: RTL and testbench

Sequential instruction encoder and loader for the single-cycle CPU. It is the inverse of the opcode decoder. It accepts symbolic operations (kind, rd, rs1, rs2, imm) over a valid/ready handshake and encodes each one into a 32-bit RV32 word. It then writes the word into instruction memory at consecutive word addresses. Bench and boot logic use it to preload programs that the CPU control path later decodes.

---
 rtl/instr_encoder_loader.sv | 155 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic RV32 operations into 32-bit words and writes them to consecutive memory words.
// Define INSTR_ENC_NOP_PAD_EN to let flush_i fill the remaining memory with NOPs.
module instr_encoder_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [11:0] imm_i,
  input  logic        flush_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [15:0] count_o,
  output logic        err_o
);
  localparam logic [15:0] DepthW = 16'(DEPTH);
  localparam logic [6:0]  OpR    = 7'b0110011;
  localparam logic [6:0]  OpI    = 7'b0010011;

`ifdef INSTR_ENC_NOP_PAD_EN
  localparam logic [31:0] Nop = 32'h0000_0013;
  typedef enum logic [2:0] {StIdle, StEnc, StWr, StFull, StPad} state_e;
`else
  typedef enum logic [1:0] {StIdle, StEnc, StWr, StFull} state_e;
  logic w_unused_flush;
  assign w_unused_flush = flush_i;
`endif

  state_e      r_state;
  logic [3:0]  r_kind;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [11:0] r_imm;
  logic        r_ready, r_we, r_err;
  logic [31:0] r_addr, r_data;
  logic [15:0] r_count;

  logic [31:0] w_word;
  logic        w_legal;
  logic [15:0] w_count_inc;
  logic [31:0] w_addr;

  assign w_count_inc = r_count + 16'd1;
  assign w_addr      = BASE_ADDR + {14'd0, r_count, 2'b00};

  // Encoding works from the captured request so inputs may change after the handshake.
  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (r_kind)
      4'd0:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b000, r_rd, OpR};
      4'd1:    w_word = {7'b0100000, r_rs2, r_rs1, 3'b000, r_rd, OpR};
      4'd2:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b111, r_rd, OpR};
      4'd3:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b110, r_rd, OpR};
      4'd4:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b100, r_rd, OpR};
      4'd5:    w_word = {7'b0000000, r_rs2, r_rs1, 3'b001, r_rd, OpR};
      4'd6:    w_word = {7'b0000001, r_rs2, r_rs1, 3'b000, r_rd, OpR};
      4'd7:    w_word = {r_imm, r_rs1, 3'b000, r_rd, OpI};
      4'd8:    w_word = {7'b0100000, r_imm[4:0], r_rs1, 3'b101, r_rd, OpI};
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_kind  <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_data  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        StIdle: begin
          if (req_valid_i && r_ready) begin
            r_kind  <= kind_i;
            r_rd    <= rd_i;
            r_rs1   <= rs1_i;
            r_rs2   <= rs2_i;
            r_imm   <= imm_i;
            r_ready <= 1'b0;
            r_state <= StEnc;
`ifdef INSTR_ENC_NOP_PAD_EN
          end else if (flush_i) begin
            r_ready <= 1'b0;
            if (r_count == DepthW) begin
              r_state <= StFull;
            end else begin
              r_state <= StPad;
              r_we    <= 1'b1;
              r_addr  <= w_addr;
              r_data  <= Nop;
            end
`endif
          end
        end
        StEnc: begin
          if (w_legal) begin
            r_state <= StWr;
            r_we    <= 1'b1;
            r_addr  <= w_addr;
            r_data  <= w_word;
          end else begin
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= StIdle;
          end
        end
        StWr: begin
          r_count <= w_count_inc;
          if (w_count_inc == DepthW) begin
            r_state <= StFull;
          end else begin
            r_state <= StIdle;
            r_ready <= 1'b1;
          end
        end
`ifdef INSTR_ENC_NOP_PAD_EN
        StPad: begin
          // One NOP per cycle; the strobe stays high until the last word has been written.
          r_count <= w_count_inc;
          if (w_count_inc == DepthW) begin
            r_state <= StFull;
          end else begin
            r_we   <= 1'b1;
            r_addr <= BASE_ADDR + {14'd0, w_count_inc, 2'b00};
          end
        end
`endif
        StFull:  r_ready <= 1'b0;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_data_o  = r_data;
  assign count_o     = r_count;
  assign err_o       = r_err;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed program vectors plus randomized traffic,
// checked against an arithmetic encoding model and a cycle-level timing model.
module tb_instr_encoder_loader;
  localparam int unsigned DEPTH = 6;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  kind_i = '0;
  logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [11:0] imm_i = '0;
  logic        flush_i = 1'b0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [15:0] count_o;
  logic        err_o;

  instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .kind_i(kind_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .flush_i(flush_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          inc_q[$];
  int          checks = 0, errors = 0;
  logic [31:0] last_addr = BASE, last_data = '0;
  int          busy_until = 0, err_at = NEVER, exp_count = 0;
  bit          exp_err = 1'b0;

  int f3_tab[7] = '{0, 0, 7, 6, 4, 1, 0};
  int f7_tab[7] = '{0, 32, 0, 0, 0, 0, 1};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // RV32 word built from field weights rather than bit concatenation.
  function automatic logic [31:0] model_enc(int kind, int rd, int rs1, int rs2, int imm);
    longint w;
    if (kind <= 6)
      w = longint'(f7_tab[kind]) * 33554432 + longint'(rs2) * 1048576 + longint'(rs1) * 32768
        + longint'(f3_tab[kind]) * 4096 + longint'(rd) * 128 + 51;
    else if (kind == 7)
      w = longint'(imm) * 1048576 + longint'(rs1) * 32768 + longint'(rd) * 128 + 19;
    else
      w = longint'(1024 + imm % 32) * 1048576 + longint'(rs1) * 32768 + 5 * 4096
        + longint'(rd) * 128 + 19;
    return w[31:0];
  endfunction

  // Monitor: runs on the falling edge, before the driver touches inputs.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr_o,
                   mem_data_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("write_addr", mem_addr_o, e.addr);
          chk("write_data", mem_data_o, e.data);
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        chk("hold_addr", mem_addr_o, last_addr);
        chk("hold_data", mem_data_o, last_data);
      end
    end
  end

  task automatic step(input bit v, input int kind, input int rd, input int rs1, input int rs2,
                      input int imm, input bit fl, input bit use_lit, input logic [31:0] lit,
                      output bit acc);
    bit  exp_ready;
    wr_t e;
    @(negedge clk);
    #1;
    while (inc_q.size() > 0 && inc_q[0] <= cyc) begin
      void'(inc_q.pop_front());
      exp_count++;
    end
    if (err_at <= cyc) exp_err = 1'b1;
    exp_ready = (cyc >= busy_until) && (exp_count < DEPTH);
    chk("ready", 32'(req_ready_o), 32'(exp_ready));
    chk("count", 32'(count_o), exp_count);
    chk("err", 32'(err_o), 32'(exp_err));
    req_valid_i = v;
    kind_i = 4'(kind);
    rd_i = 5'(rd);
    rs1_i = 5'(rs1);
    rs2_i = 5'(rs2);
    imm_i = 12'(imm);
    flush_i = fl;
    acc = 1'b0;
    if (v && exp_ready) begin
      acc = 1'b1;
      if (kind <= 8) begin
        e.cyc  = cyc + 2;
        e.addr = BASE + 32'(4 * exp_count);
        e.data = use_lit ? lit : model_enc(kind, rd, rs1, rs2, imm);
        exp_q.push_back(e);
        inc_q.push_back(cyc + 3);
        busy_until = cyc + 3;
      end else begin
        busy_until = cyc + 2;
        err_at = cyc + 2;
      end
`ifdef INSTR_ENC_NOP_PAD_EN
    end else if (fl && exp_ready) begin
      for (int j = 0; j < int'(DEPTH) - exp_count; j++) begin
        e.cyc  = cyc + 1 + j;
        e.addr = BASE + 32'(4 * (exp_count + j));
        e.data = 32'h0000_0013;
        exp_q.push_back(e);
        inc_q.push_back(cyc + 2 + j);
      end
      busy_until = NEVER;
`endif
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, '0, acc);
  endtask

  task automatic send(input int kind, input int rd, input int rs1, input int rs2, input int imm,
                      input bit use_lit, input logic [31:0] lit);
    bit acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++)
      step(1'b1, kind, rd, rs1, rs2, imm, 1'b0, use_lit, lit, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake expected one within 20 cycles");
    end
  endtask

  task automatic drain();
    for (int g = 0; g < 40 && (exp_q.size() > 0 || inc_q.size() > 0); g++) idle(1);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d writes outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_write: got none expected addr %h data %h", exp_q[0].addr,
               exp_q[0].data);
      void'(exp_q.pop_front());
    end
    exp_q.delete();
    inc_q.delete();
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    flush_i = 1'b0;
    last_addr = BASE;
    last_data = '0;
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, BASE);
    chk("rst_data", mem_data_o, 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_i = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
    busy_until = 0;
    err_at = NEVER;
  endtask

  initial begin
    bit acc;
    do_reset();
    send(0, 1, 2, 3, 0, 1'b1, 32'h003100B3);
    idle(4);
    do_reset();
    send(7, 1, 0, 0, 5, 1'b1, 32'h00500093);
    send(1, 5, 6, 7, 0, 1'b1, 32'h407302B3);
    send(8, 4, 4, 9, 12'hFE3, 1'b1, 32'h40325213);
    send(6, 1, 2, 3, 0, 1'b1, 32'h023100B3);
    send(12, 3, 3, 3, 0, 1'b0, '0);
    idle(3);
    send(2, 7, 8, 9, 0, 1'b0, '0);
    send(7, 31, 30, 0, 12'h800, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b1, 3, i, i, i, 0, 1'b0, 1'b0, '0, acc);
    drain();

    // Reset during ENC after an error, then reset during WR.
    do_reset();
    send(15, 0, 0, 0, 0, 1'b0, '0);
    idle(3);
    send(4, 1, 1, 1, 0, 1'b0, '0);
    do_reset();
    send(5, 2, 3, 4, 0, 1'b0, '0);
    idle(1);
    do_reset();
    idle(2);

    for (int p = 0; p < 8; p++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        int kind;
        kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) :
                                             int'($urandom_range(0, 8));
        if ($urandom_range(0, 99) == 0) do_reset();
        else step($urandom_range(0, 9) < 7, kind, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 4095), $urandom_range(0, 19) == 0,
                  1'b0, '0, acc);
      end
      drain();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
